// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv
// Purpose  : Iterative RV64M multiply/divide unit beside the execute-stage ALU.
// Revision : 1.0  initial release
// ============================================================================
module exe_muldiv #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req,
    input  logic [2:0]      funct3,
    input  logic            word32,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   N_FULL   = CW'(XLEN / BITS_PER_CYCLE - 1);
    localparam logic [CW-1:0]   N_WORD   = CW'(32 / BITS_PER_CYCLE - 1);
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [2:0]        funct3_q;
    logic              word32_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic [XLEN-1:0]   a_q;
    logic [2*XLEN-1:0] b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Operand preparation and divide special-case detection, evaluated in IDLE.
    logic            sgn_a_d;
    logic            sgn_b_d;
    logic            neg_a_d;
    logic            neg_b_d;
    logic [XLEN-1:0] aw_d;
    logic [XLEN-1:0] op_a_d;
    logic [XLEN-1:0] op_b_d;
    logic [XLEN-1:0] mag_a_d;
    logic [XLEN-1:0] mag_b_d;
    logic            div0_d;
    logic            ovf_d;
    logic            special_d;
    logic [XLEN-1:0] spec_res_d;

    always_comb begin
        sgn_a_d    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b_d    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        aw_d       = word32 ? sext32(in_a[31:0]) : in_a;
        op_a_d     = (word32 && !sgn_a_d) ? zext32(in_a[31:0]) : aw_d;
        op_b_d     = word32 ? (sgn_b_d ? sext32(in_b[31:0]) : zext32(in_b[31:0])) : in_b;
        neg_a_d    = sgn_a_d & op_a_d[XLEN-1];
        neg_b_d    = sgn_b_d & op_b_d[XLEN-1];
        mag_a_d    = neg_a_d ? -op_a_d : op_a_d;
        mag_b_d    = neg_b_d ? -op_b_d : op_b_d;
        div0_d     = (op_b_d == '0);
        ovf_d      = funct3[2] & ~funct3[0] & (&op_b_d) &
                     (op_a_d == (word32 ? sext32(32'h8000_0000) : MIN_FULL));
        special_d  = funct3[2] & (div0_d | ovf_d);
        // Overflow quotient equals the dividend (min), so both cases reuse aw_d.
        spec_res_d = funct3[1] ? (div0_d ? aw_d : '0) : (div0_d ? '1 : aw_d);
    end

    // One BUSY cycle retires BITS_PER_CYCLE shift-add or restoring-divide steps.
    logic [XLEN-1:0]   a_d;
    logic [2*XLEN-1:0] b_d;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN:0]     trial_d;
    logic [XLEN:0]     diff_d;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        trial_d = '0;
        diff_d  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (funct3_q[2]) begin
                trial_d         = {acc_d[XLEN-1:0], a_d[XLEN-1]};
                diff_d          = trial_d - {1'b0, b_d[XLEN-1:0]};
                acc_d[XLEN-1:0] = diff_d[XLEN] ? trial_d[XLEN-1:0] : diff_d[XLEN-1:0];
                a_d             = {a_d[XLEN-2:0], ~diff_d[XLEN]};
            end else begin
                if (a_d[0]) begin
                    acc_d = acc_d + b_d;
                end
                b_d = b_d << 1;
                a_d = a_d >> 1;
            end
        end
    end

    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   quo_d;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   res_d;

    always_comb begin
        prod_d = neg_res_q ? -acc_d : acc_d;
        quo_d  = neg_res_q ? -a_d : a_d;
        rem_d  = neg_rem_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        case (funct3_q)
            3'b000:                 res_d = word32_q ? sext32(prod_d[31:0]) : prod_d[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_d = prod_d[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_d = word32_q ? sext32(quo_d[31:0]) : quo_d;
            default:                res_d = word32_q ? sext32(rem_d[31:0]) : rem_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            funct3_q  <= '0;
            word32_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req && !flush) begin
                        funct3_q  <= funct3;
                        word32_q  <= word32;
                        neg_res_q <= neg_a_d ^ neg_b_d;
                        neg_rem_q <= funct3[2] & neg_a_d;
                        acc_q     <= '0;
                        cnt_q     <= word32 ? N_WORD : N_FULL;
                        busy_q    <= 1'b1;
                        if (funct3[2]) begin
                            // Word dividends sit in the top half so quotient bits land low.
                            a_q <= word32 ? (mag_a_d << (XLEN - 32)) : mag_a_d;
                            b_q <= {{XLEN{1'b0}}, mag_b_d};
                        end else begin
                            a_q <= mag_b_d;
                            b_q <= {{XLEN{1'b0}}, mag_a_d};
                        end
                        if (special_d) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= spec_res_d;
                        end else begin
                            state_q  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= res_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv.sv
`default_nettype none
// Directed bench for exe_muldiv at XLEN=64, BITS_PER_CYCLE=2.
module tb_exe_muldiv;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req;
    logic [2:0]  funct3;
    logic        word32;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;

    exe_muldiv #(
        .XLEN           (64),
        .BITS_PER_CYCLE (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .req    (req),
        .funct3 (funct3),
        .word32 (word32),
        .in_a   (in_a),
        .in_b   (in_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Drives a request for one cycle; returns #1 after the accept edge (cycle 1).
    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        funct3 = f3;
        word32 = w;
        in_a   = a;
        in_b   = b;
        req    = 1'b1;
        @(posedge clk);
        #1;
        req    = 1'b0;
        funct3 = 3'b011;
        word32 = 1'b0;
        in_a   = 64'hA5A5_5A5A_C3C3_3C3C;
        in_b   = 64'h0123_4567_89AB_CDEF;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int exp_cyc, input logic [63:0] exp_res);
        int cyc;
        issue(f3, w, a, b);
        cyc = 1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        chk(tag, result, exp_res);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        rst    = 1'b0;
        flush  = 1'b0;
        req    = 1'b0;
        funct3 = 3'b000;
        word32 = 1'b0;
        in_a   = '0;
        in_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul",    3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 33, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mulhu",  3'b011, 1'b0, '1, '1, 33, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulh",   3'b001, 1'b0, '1, '1, 33, 64'h0);
        run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulw",   3'b000, 1'b1, 64'h1_0000_0003, 64'h0000_0000_FFFF_FFFF, 17, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_by0", 3'b101, 1'b0, 64'd7, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem_by0",  3'b110, 1'b0, 64'd7, 64'd0, 1, 64'd7);
        run_op("div_ovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000);
        run_op("rem_ovf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h0);
        run_op("divw",   3'b100, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 17, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remw",   3'b110, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 17, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remuw",  3'b111, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 17, 64'd1);
        run_op("div_neg", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("rem_neg", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("divuw_by0", 3'b101, 1'b1, 64'h1_8000_0000, 64'h5_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remuw_by0", 3'b111, 1'b1, 64'h1_8000_0000, 64'h5_0000_0000, 1, 64'hFFFF_FFFF_8000_0000);

        // Request together with flush in IDLE is dropped.
        @(negedge clk);
        funct3 = 3'b101;
        in_a   = 64'd100;
        in_b   = 64'd7;
        req    = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        req    = 1'b0;
        flush  = 1'b0;
        chk("req_flush_ignored", {62'd0, busy, done}, 64'd0);

        // Flush in BUSY cycle 10 kills the op; the next request is taken in cycle 11.
        issue(3'b000, 1'b0, 64'd5, 64'd9);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("flush_c10_state", {62'd0, busy, done}, 64'd2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_c11_state", {62'd0, busy, done}, 64'd0);
        run_op("divu_after_flush", 3'b101, 1'b0, 64'd100, 64'd7, 33, 64'd14);

        // Asynchronous reset mid-BUSY clears all outputs immediately.
        issue(3'b100, 1'b0, 64'd1000, 64'd3);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy",   64'(busy), 64'd0);
        chk("midrst_done",   64'(done), 64'd0);
        chk("midrst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("div_after_rst", 3'b100, 1'b0, 64'd1000, 64'd3, 33, 64'd333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
